// File: rtl/reset_sequencer.sv
// Staged reset release for up to four clock-domain resets, restartable by a debounced
// push button or a single-cycle software request.
module reset_sequencer #(
  parameter int unsigned CLOCK_HZ        = 48000000,
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned STAGE_CYCLES    = 255,
  parameter int unsigned DEBOUNCE_CYCLES = CLOCK_HZ / 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_n,
  input  logic                  soft_req,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  busy,
  output logic [1:0]            stage_idx,
  output logic                  counter_non_zero
);

  localparam int unsigned CntW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(STAGE_CYCLES - 1);
  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_CYCLES);
  localparam logic [DebW-1:0] DebFire = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] LastIdx = 2'(NUM_STAGES - 1);

  typedef enum logic [0:0] {StSeq, StRun} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      btn_sync_q;
  logic [DebW-1:0] deb_cnt_q;
  logic            btn_s;
  logic            press;
  logic            restart;

  // Synchronizer flops reset to 1 so a held-low reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q <= 2'b11;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn_n};
    end
  end

  assign btn_s = btn_sync_q[1];

  // Count saturates at DebMax so a long press fires exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
    end else if (btn_s) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q != DebMax) begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign press   = !btn_s && (deb_cnt_q == DebFire);
  assign restart = press || soft_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSeq;
      stage_reset <= '1;
      busy        <= 1'b1;
      stage_idx   <= 2'd0;
      cnt_q       <= CntLoad;
    end else if (restart) begin
      state_q     <= StSeq;
      stage_reset <= '1;
      busy        <= 1'b1;
      stage_idx   <= 2'd0;
      cnt_q       <= CntLoad;
    end else begin
      unique case (state_q)
        StSeq: begin
          if (cnt_q == '0) begin
            // Bit 0 releases first, so shifting in zeros from the bottom works.
            stage_reset <= stage_reset << 1;
            stage_idx   <= (stage_idx == 2'd3) ? 2'd3 : stage_idx + 2'd1;
            if (stage_idx == LastIdx) begin
              state_q <= StRun;
              busy    <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= CntLoad;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRun: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= StSeq;
        end
      endcase
    end
  end

  assign counter_non_zero = |cnt_q;

endmodule
